// File: rtl/calculadora_n.sv
// Digit-entry calculator: builds A and B from decimal digits, computes +,-,*,/ (mul/div bit-serial over WIDTH cycles).
// Optional operator chaining from DONE is enabled by defining CALC_CHAIN_EN.
module calculadora_n #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 8,
    parameter int POS_W      = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       cmd,
    input  logic             cmd_valid,
    output logic [1:0]       status,
    output logic [3:0]       data,
    output logic [POS_W-1:0] position,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_IN_A    = 3'd1;
    localparam logic [2:0] S_OP      = 3'd2;
    localparam logic [2:0] S_IN_B    = 3'd3;
    localparam logic [2:0] S_COMPUTE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    localparam logic [3:0] C_ADD = 4'hA;
    localparam logic [3:0] C_SUB = 4'hB;
    localparam logic [3:0] C_MUL = 4'hC;
    localparam logic [3:0] C_EQ  = 4'hE;
    localparam logic [3:0] C_CLR = 4'hF;

    localparam int NW = $clog2(MAX_DIGITS + 1);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [NW-1:0] N_MAX = NW'(MAX_DIGITS);

    logic [2:0]         state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d, op_b_q, op_b_d, acc_q, acc_d;
    logic [NW-1:0]      na_q, na_d, nb_q, nb_d;
    logic [3:0]         op_sel_q, op_sel_d, data_q, data_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic               is_digit, is_op;
    logic [WIDTH-1:0]   dig_w;
    logic [WIDTH:0]     add_sum, mul_sum, rem_sh, rem_sub;
    logic [2*WIDTH-1:0] mul_step, div_step;

    assign is_digit = (cmd <= 4'd9);
    assign is_op    = (cmd >= C_ADD) && (cmd <= 4'hD);
    assign dig_w    = {{(WIDTH-4){1'b0}}, cmd};
    assign add_sum  = {1'b0, op_a_q} + {1'b0, op_b_q};

    // Multiply: prod holds {partial sum, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, op_a_q} : '0);
    assign mul_step = {mul_sum, prod_q[WIDTH-1:1]};

    // Divide: prod holds {remainder, quotient}; quotient bits enter from the right.
    assign rem_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign rem_sub  = rem_sh - {1'b0, op_b_q};
    assign div_step = (rem_sh >= {1'b0, op_b_q})
                    ? {rem_sub[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1}
                    : {rem_sh[WIDTH-1:0],  prod_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        acc_d    = acc_q;
        na_d     = na_q;
        nb_d     = nb_q;
        op_sel_d = op_sel_q;
        data_d   = data_q;
        pos_d    = pos_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (cmd_valid && is_digit) begin
                    op_a_d  = dig_w;
                    na_d    = NW'(1);
                    data_d  = cmd;
                    pos_d   = '0;
                    state_d = S_IN_A;
                end else if (cmd_valid && cmd == C_CLR && state_q == S_DONE) begin
                    data_d  = C_CLR;
                    pos_d   = '0;
                    state_d = S_IDLE;
                end
`ifdef CALC_CHAIN_EN
                else if (cmd_valid && is_op && state_q == S_DONE) begin
                    op_a_d   = acc_q;
                    na_d     = N_MAX;
                    op_sel_d = cmd;
                    data_d   = cmd;
                    state_d  = S_OP;
                end
`endif
            end
            S_IN_A, S_IN_B: begin
                if (cmd_valid && is_digit) begin
                    if ((state_q == S_IN_A ? na_q : nb_q) == N_MAX) begin
                        state_d = S_ERROR;
                    end else if (state_q == S_IN_A) begin
                        op_a_d = (op_a_q << 3) + (op_a_q << 1) + dig_w;
                        data_d = cmd;
                        pos_d  = POS_W'(na_q);
                        na_d   = na_q + NW'(1);
                    end else begin
                        op_b_d = (op_b_q << 3) + (op_b_q << 1) + dig_w;
                        data_d = cmd;
                        pos_d  = POS_W'(nb_q);
                        nb_d   = nb_q + NW'(1);
                    end
                end else if (cmd_valid && is_op && state_q == S_IN_A) begin
                    op_sel_d = cmd;
                    op_b_d   = '0;
                    nb_d     = '0;
                    data_d   = cmd;
                    pos_d    = '0;
                    state_d  = S_OP;
                end else if (cmd_valid && cmd == C_CLR) begin
                    op_b_d  = (state_q == S_IN_B) ? '0 : op_b_q;
                    nb_d    = (state_q == S_IN_B) ? '0 : nb_q;
                    data_d  = C_CLR;
                    pos_d   = '0;
                    state_d = (state_q == S_IN_B) ? S_OP : S_IDLE;
                end else if (cmd_valid && cmd == C_EQ && state_q == S_IN_B) begin
                    case (op_sel_q)
                        C_ADD: begin
                            acc_d   = add_sum[WIDTH-1:0];
                            state_d = add_sum[WIDTH] ? S_ERROR : S_DONE;
                        end
                        C_SUB: begin
                            acc_d   = (op_a_q < op_b_q) ? acc_q : op_a_q - op_b_q;
                            state_d = (op_a_q < op_b_q) ? S_ERROR : S_DONE;
                        end
                        C_MUL: begin
                            prod_d  = {{WIDTH{1'b0}}, op_b_q};
                            cnt_d   = CW'(WIDTH);
                            state_d = S_COMPUTE;
                        end
                        default: begin
                            prod_d  = {{WIDTH{1'b0}}, op_a_q};
                            cnt_d   = CW'(WIDTH);
                            state_d = (op_b_q == '0) ? S_ERROR : S_COMPUTE;
                        end
                    endcase
                end
            end
            S_OP: begin
                if (cmd_valid && is_digit) begin
                    op_b_d  = dig_w;
                    nb_d    = NW'(1);
                    data_d  = cmd;
                    pos_d   = '0;
                    state_d = S_IN_B;
                end else if (cmd_valid && is_op) begin
                    op_sel_d = cmd;
                    data_d   = cmd;
                end else if (cmd_valid && cmd == C_EQ) begin
                    state_d = S_ERROR;
                end else if (cmd_valid && cmd == C_CLR) begin
                    data_d  = C_CLR;
                    pos_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_COMPUTE: begin
                if (cmd_valid && cmd == C_CLR) begin
                    data_d  = C_CLR;
                    pos_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    prod_d = (op_sel_q == C_MUL) ? mul_step : div_step;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        acc_d   = prod_d[WIDTH-1:0];
                        state_d = (op_sel_q == C_MUL && mul_step[2*WIDTH-1:WIDTH] != '0)
                                ? S_ERROR : S_DONE;
                    end
                end
            end
            S_ERROR: begin
                if (cmd_valid && cmd == C_CLR) begin
                    data_d  = C_CLR;
                    pos_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            acc_q    <= '0;
            na_q     <= '0;
            nb_q     <= '0;
            op_sel_q <= '0;
            data_q   <= '0;
            pos_q    <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            acc_q    <= acc_d;
            na_q     <= na_d;
            nb_q     <= nb_d;
            op_sel_q <= op_sel_d;
            data_q   <= data_d;
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end

    assign status       = (state_q == S_COMPUTE) ? 2'd1 : (state_q == S_ERROR) ? 2'd2 : 2'd0;
    assign data         = data_q;
    assign position     = pos_q;
    assign result_valid = (state_q == S_DONE);
    assign result       = (state_q == S_DONE) ? acc_q : '0;
endmodule

// File: tb/tb_calculadora_n.sv
// Directed test-plan steps plus randomized operand/operator runs checked against plain arithmetic.
module tb_calculadora_n;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   cmd;
    logic         cmd_valid;
    logic [1:0]   status;
    logic [3:0]   data;
    logic [2:0]   position;
    logic [W-1:0] result;
    logic         result_valid;

    int n_cmp = 0;
    int n_err = 0;

    calculadora_n #(.WIDTH(W), .MAX_DIGITS(8), .POS_W(3)) dut (
        .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .status(status), .data(data), .position(position),
        .result(result), .result_valid(result_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] c, input logic v);
        cmd = c;
        cmd_valid = v;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Occasionally precede a command with a junk cycle that has cmd_valid low.
    task automatic send(input logic [3:0] c);
        if ($urandom_range(0, 3) == 0) step(4'($urandom_range(0, 15)), 1'b0);
        step(c, 1'b1);
    endtask

    // While busy, feed random non-clear commands; bounded so a stuck DUT cannot hang the run.
    task automatic wait_busy(output int busy);
        busy = 0;
        while (status == 2'd1 && busy < 200) begin
            if ($urandom_range(0, 1) == 0) step(4'($urandom_range(0, 14)), 1'b1);
            else step(4'($urandom_range(0, 15)), 1'b0);
            busy++;
        end
    endtask

    task automatic enter_num(input int nd, input string tag, output longint val);
        logic [3:0] d;
        val = 0;
        for (int i = 0; i < nd; i++) begin
            d = 4'($urandom_range(0, 9));
            send(d);
            chk({tag, "_data"}, 64'(data), 64'(d));
            chk({tag, "_pos"}, 64'(position), 64'(i));
            val = val * 10 + longint'(d);
        end
    endtask

    initial begin
        int busy;
        longint a, b, expv;
        bit     exp_err;
        logic [3:0] op;

        reset = 1'b1;
        cmd = 4'h0;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_status", 64'(status), 0);
        chk("rst_data", 64'(data), 0);
        chk("rst_pos", 64'(position), 0);
        chk("rst_result", 64'(result), 0);
        chk("rst_rvalid", 64'(result_valid), 0);
        reset = 1'b0;

        // 12 + 34
        step(4'd1, 1); chk("add_pos0", 64'(position), 0); chk("add_st", 64'(status), 0);
        step(4'd2, 1); chk("add_pos1", 64'(position), 1); chk("add_data", 64'(data), 2);
        step(4'hA, 1); chk("add_opdata", 64'(data), 10);
        step(4'd3, 1); step(4'd4, 1); chk("add_st2", 64'(status), 0);
        step(4'hE, 1);
        chk("add_rvalid", 64'(result_valid), 1);
        chk("add_result", 64'(result), 46);
        chk("add_st3", 64'(status), 0);
        step(4'hF, 1);
        chk("clr_data", 64'(data), 15);
        chk("clr_rvalid", 64'(result_valid), 0);

        // 7 * 6
        step(4'd7, 1); chk("mul_pos_a", 64'(position), 0);
        step(4'hC, 1);
        step(4'd6, 1); chk("mul_pos_b", 64'(position), 0);
        step(4'hE, 1);
        wait_busy(busy);
        chk("mul_busy", 64'(busy), 32);
        chk("mul_result", 64'(result), 42);
        chk("mul_rvalid", 64'(result_valid), 1);

        // 5 - 9 underflows
        step(4'hF, 1); step(4'd5, 1); step(4'hB, 1); step(4'd9, 1); step(4'hE, 1);
        chk("sub_err_st", 64'(status), 2);
        chk("sub_err_rv", 64'(result_valid), 0);
        step(4'hF, 1);
        chk("err_clr_st", 64'(status), 0);
        chk("err_clr_data", 64'(data), 15);

        // Ninth digit overflows the operand
        for (int i = 1; i <= 8; i++) step(4'(i), 1);
        chk("dig8_pos", 64'(position), 7);
        chk("dig8_st", 64'(status), 0);
        step(4'd9, 1);
        chk("dig9_st", 64'(status), 2);
        chk("dig9_data", 64'(data), 8);

        // 100 / 0
        step(4'hF, 1);
        step(4'd1, 1); step(4'd0, 1); step(4'd0, 1); step(4'hD, 1); step(4'd0, 1); step(4'hE, 1);
        chk("div0_st", 64'(status), 2);

        // 100 / 7
        step(4'hF, 1);
        step(4'd1, 1); step(4'd0, 1); step(4'd0, 1); step(4'hD, 1); step(4'd7, 1); step(4'hE, 1);
        wait_busy(busy);
        chk("div_busy", 64'(busy), 32);
        chk("div_result", 64'(result), 14);

        // Reset in the tenth compute cycle
        step(4'hF, 1);
        step(4'd1, 1); step(4'd0, 1); step(4'd0, 1); step(4'hD, 1); step(4'd7, 1); step(4'hE, 1);
        repeat (9) step(4'h0, 0);
        chk("mid_busy", 64'(status), 1);
        reset = 1'b1;
        step(4'h0, 0);
        reset = 1'b0;
        chk("mid_rst_st", 64'(status), 0);
        chk("mid_rst_data", 64'(data), 0);
        chk("mid_rst_rv", 64'(result_valid), 0);
        chk("mid_rst_res", 64'(result), 0);
        repeat (3) step(4'h0, 0);
        chk("mid_rst_hold", 64'(status), 0);
        step(4'd3, 1);
        chk("post_rst_data", 64'(data), 3);
        chk("post_rst_pos", 64'(position), 0);

        // Chaining from DONE
        step(4'hF, 1);
        step(4'd2, 1); step(4'hA, 1); step(4'd3, 1); step(4'hE, 1);
        chk("chain_first", 64'(result), 5);
        step(4'hA, 1);
`ifdef CALC_CHAIN_EN
        chk("chain_op_rv", 64'(result_valid), 0);
        chk("chain_op_data", 64'(data), 10);
        step(4'd4, 1); step(4'hE, 1);
        chk("chain_result", 64'(result), 9);
        chk("chain_rv", 64'(result_valid), 1);
`else
        chk("nochain_rv", 64'(result_valid), 1);
        chk("nochain_result", 64'(result), 5);
`endif

        // Randomized operations against plain arithmetic
        for (int t = 0; t < 24; t++) begin
            send(4'hF);
            op = 4'($urandom_range(10, 13));
            if (op == 4'hC) enter_num($urandom_range(1, 5), "rnd_a", a);
            else            enter_num($urandom_range(1, 8), "rnd_a", a);
            send(op);
            chk("rnd_opdata", 64'(data), 64'(op));
            if (op == 4'hC)      enter_num($urandom_range(1, 5), "rnd_b", b);
            else if (op == 4'hD) enter_num($urandom_range(1, 3), "rnd_b", b);
            else                 enter_num($urandom_range(1, 8), "rnd_b", b);
            exp_err = 1'b0;
            expv = 0;
            case (op)
                4'hA: expv = a + b;
                4'hB: begin exp_err = (a < b); expv = a - b; end
                4'hC: begin expv = a * b; exp_err = (expv >= 64'h1_0000_0000); end
                default: begin exp_err = (b == 0); expv = (b == 0) ? 0 : a / b; end
            endcase
            send(4'hE);
            wait_busy(busy);
            if (exp_err) begin
                chk("rnd_err_st", 64'(status), 2);
                chk("rnd_err_rv", 64'(result_valid), 0);
            end else begin
                chk("rnd_busy", 64'(busy), (op >= 4'hC) ? 32 : 0);
                chk("rnd_rv", 64'(result_valid), 1);
                chk("rnd_result", 64'(result), expv);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
